// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if -- issue/write-back bundle between the decoder, the
// write-back stage and the register-dependency scoreboard.
//
// Parameter:
//   CNT_W         width of each per-register pending counter
// Signals:
//   issueValid    decoder presents an instruction this cycle
//   issueSrc1     first source register number
//   issueSrc2     second source register number
//   issueUseSrc2  instruction reads issueSrc2
//   issueWbEn     instruction will write back issueDest
//   issueDest     destination register number
//   writeBackEn   write-back stage retires a write this cycle
//   destWB        register retired by the write-back
//   stall         combinational; instruction must not issue this cycle
//   inFlight      registered total of outstanding writes
//   wbErr         registered, sticky retire-with-nothing-pending flag
//
// Handshake: an instruction is accepted in any cycle where issueValid=1 and
// stall=0; while stall=1 the decoder holds every issue* signal unchanged.
// writeBackEn is a plain strobe with no back-pressure.
// Modports: master = decoder/write-back side, slave = scoreboard.

interface reg_scoreboard_if #(
    parameter int CNT_W = 2
);
    logic             issueValid;
    logic [3:0]       issueSrc1;
    logic [3:0]       issueSrc2;
    logic             issueUseSrc2;
    logic             issueWbEn;
    logic [3:0]       issueDest;
    logic             writeBackEn;
    logic [3:0]       destWB;
    logic             stall;
    logic [CNT_W+3:0] inFlight;
    logic             wbErr;

    modport master (
        output issueValid, issueSrc1, issueSrc2, issueUseSrc2,
               issueWbEn, issueDest, writeBackEn, destWB,
        input  stall, inFlight, wbErr
    );

    modport slave (
        input  issueValid, issueSrc1, issueSrc2, issueUseSrc2,
               issueWbEn, issueDest, writeBackEn, destWB,
        output stall, inFlight, wbErr
    );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard -- register-dependency scoreboard for R0..R15.
//
// Keeps a saturating-free pending-write counter per architectural register.
// An instruction stalls while any source it reads has writes outstanding, or
// while its destination counter is already at its maximum. Retires from the
// write-back stage decrement the counters; a retire to a register with
// nothing pending sets a sticky error flag instead.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   reg_scoreboard_if.slave (issue inputs, write-back inputs,
//         stall / inFlight / wbErr outputs)
//
// Build option:
//   SCOREBOARD_BYPASS_EN  when defined, a source whose only pending write is
//                         retiring in this same cycle does not stall (the
//                         register file forwards the write data). Destination
//                         fullness never uses the bypass.

module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    reg_scoreboard_if.slave   bus
);
    localparam int IF_W = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IF_W-1:0]  IF_ONE   = IF_W'(1);

    logic [CNT_W-1:0] pend [16];
    logic [IF_W-1:0]  in_flight_q;
    logic             wb_err_q;

    logic [CNT_W-1:0] src1_cnt;
    logic [CNT_W-1:0] src2_cnt;
    logic [CNT_W-1:0] dest_cnt;
    logic [CNT_W-1:0] wb_cnt;
    logic             src1_hit;
    logic             src2_hit;
    logic             dest_full;
    logic             stall_c;
    logic             issue_wr;
    logic             retire_ok;
    logic             retire_bad;
`ifdef SCOREBOARD_BYPASS_EN
    logic             src1_byp;
    logic             src2_byp;
`endif

    always_comb begin
        src1_cnt   = pend[bus.issueSrc1];
        src2_cnt   = pend[bus.issueSrc2];
        dest_cnt   = pend[bus.issueDest];
        wb_cnt     = pend[bus.destWB];

`ifdef SCOREBOARD_BYPASS_EN
        // Last outstanding write to this source retires now; the register
        // file forwards it, so the read can proceed this cycle.
        src1_byp   = (src1_cnt == CNT_ONE) && bus.writeBackEn &&
                     (bus.destWB == bus.issueSrc1);
        src2_byp   = (src2_cnt == CNT_ONE) && bus.writeBackEn &&
                     (bus.destWB == bus.issueSrc2);
        src1_hit   = (src1_cnt != CNT_ZERO) && !src1_byp;
        src2_hit   = bus.issueUseSrc2 && (src2_cnt != CNT_ZERO) && !src2_byp;
`else
        src1_hit   = (src1_cnt != CNT_ZERO);
        src2_hit   = bus.issueUseSrc2 && (src2_cnt != CNT_ZERO);
`endif
        // Full destination blocks issue so the counter can never wrap.
        dest_full  = bus.issueWbEn && (dest_cnt == CNT_MAX);

        stall_c    = bus.issueValid && (src1_hit || src2_hit || dest_full);
        issue_wr   = bus.issueValid && !stall_c && bus.issueWbEn;
        retire_ok  = bus.writeBackEn && (wb_cnt != CNT_ZERO);
        retire_bad = bus.writeBackEn && (wb_cnt == CNT_ZERO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                pend[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                // Increment and decrement of the same register cancel out.
                case ({issue_wr  && (bus.issueDest == 4'(i)),
                       retire_ok && (bus.destWB    == 4'(i))})
                    2'b10:   pend[i] <= pend[i] + CNT_ONE;
                    2'b01:   pend[i] <= pend[i] - CNT_ONE;
                    default: pend[i] <= pend[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_flight_q <= '0;
        end else begin
            case ({issue_wr, retire_ok})
                2'b10:   in_flight_q <= in_flight_q + IF_ONE;
                2'b01:   in_flight_q <= in_flight_q - IF_ONE;
                default: in_flight_q <= in_flight_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_err_q <= 1'b0;
        end else if (retire_bad) begin
            wb_err_q <= 1'b1;
        end
    end

    assign bus.stall    = stall_c;
    assign bus.inFlight = in_flight_q;
    assign bus.wbErr    = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard -- directed bench for reg_scoreboard (CNT_W = 2).
//
// A reference model holds the pending count of every register as plain
// integers; the expected inFlight is the sum of those counts. Every falling
// edge the monitor compares stall, inFlight and wbErr against the model.
// Directed steps also pin hand-computed literal values.
// Follows SCOREBOARD_BYPASS_EN the same way the design does.

module tb_reg_scoreboard;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    reg_scoreboard_if #(.CNT_W(CNT_W)) bus ();

    reg_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_pend [16] = '{default: 0};
    int m_err = 0;

    function automatic int m_total();
        int s = 0;
        for (int i = 0; i < 16; i++) s += m_pend[i];
        return s;
    endfunction

    function automatic bit m_src_blocks(input int r);
`ifdef SCOREBOARD_BYPASS_EN
        if (m_pend[r] == 1 && bus.writeBackEn && int'(bus.destWB) == r)
            return 1'b0;
`endif
        return m_pend[r] != 0;
    endfunction

    function automatic bit m_stall();
        if (!bus.issueValid) return 1'b0;
        if (m_src_blocks(int'(bus.issueSrc1))) return 1'b1;
        if (bus.issueUseSrc2 && m_src_blocks(int'(bus.issueSrc2))) return 1'b1;
        if (bus.issueWbEn && m_pend[int'(bus.issueDest)] == CNT_MAX) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst) begin
        int wr_reg;
        int rt_reg;
        if (!rst) begin
            for (int i = 0; i < 16; i++) m_pend[i] <= 0;
            m_err <= 0;
        end else begin
            wr_reg = (bus.issueValid && !m_stall() && bus.issueWbEn) ?
                     int'(bus.issueDest) : -1;
            rt_reg = -1;
            if (bus.writeBackEn) begin
                if (m_pend[int'(bus.destWB)] == 0) m_err <= 1;
                else rt_reg = int'(bus.destWB);
            end
            for (int i = 0; i < 16; i++)
                m_pend[i] <= m_pend[i] + ((wr_reg == i) ? 1 : 0)
                                       - ((rt_reg == i) ? 1 : 0);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("mon_stall",    int'(bus.stall),    int'(m_stall()));
        chk("mon_inFlight", int'(bus.inFlight), m_total());
        chk("mon_wbErr",    int'(bus.wbErr),    m_err);
    end

    // ---------------- driver tasks ----------------
    task automatic set_issue(input bit v, input int s1, input int s2,
                             input bit use2, input bit wben, input int dst);
        bus.issueValid   = v;
        bus.issueSrc1    = 4'(s1);
        bus.issueSrc2    = 4'(s2);
        bus.issueUseSrc2 = use2;
        bus.issueWbEn    = wben;
        bus.issueDest    = 4'(dst);
    endtask

    task automatic set_wb(input bit en, input int d);
        bus.writeBackEn = en;
        bus.destWB      = 4'(d);
    endtask

    task automatic idle();
        set_issue(0, 0, 0, 0, 0, 0);
        set_wb(0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset values
        at_neg();
        chk("rst_inFlight", int'(bus.inFlight), 0);
        chk("rst_stall",    int'(bus.stall),    0);
        chk("rst_wbErr",    int'(bus.wbErr),    0);

        // Write-issue to R3
        step();
        set_issue(1, 0, 0, 0, 1, 3);
        at_neg();
        chk("wr3_stall", int'(bus.stall), 0);
        step();
        set_issue(1, 3, 0, 0, 0, 0);       // RAW on R3
        at_neg();
        chk("wr3_inFlight", int'(bus.inFlight), 1);
        chk("raw_stall", int'(bus.stall), 1);
        step();
        set_wb(1, 3);                      // retire in cycle N
        at_neg();
`ifdef SCOREBOARD_BYPASS_EN
        chk("raw_stall_N", int'(bus.stall), 0);
`else
        chk("raw_stall_N", int'(bus.stall), 1);
`endif
        step();
        set_wb(0, 0);
        at_neg();
        chk("raw_stall_N1", int'(bus.stall), 0);
        chk("raw_inFlight", int'(bus.inFlight), 0);
        step();

        // src2 gating on R5
        set_issue(1, 0, 0, 0, 1, 5);
        step();
        set_issue(1, 0, 5, 0, 0, 0);
        at_neg();
        chk("src2_off_stall", int'(bus.stall), 0);
        step();
        set_issue(1, 0, 5, 1, 0, 0);
        at_neg();
        chk("src2_on_stall", int'(bus.stall), 1);
        step();
        idle();
        set_wb(1, 5);
        step();
        idle();

        // Saturation on R7
        set_issue(1, 0, 0, 0, 1, 7);
        repeat (3) step();
        at_neg();
        chk("sat_stall",    int'(bus.stall),    1);
        chk("sat_inFlight", int'(bus.inFlight), 3);
        step();
        at_neg();
        chk("sat_hold_inFlight", int'(bus.inFlight), 3);
        step();
        idle();
        set_wb(1, 7);
        repeat (3) step();
        idle();
        at_neg();
        chk("sat_drain_inFlight", int'(bus.inFlight), 0);
        step();

        // Simultaneous issue and retire on R2
        set_issue(1, 0, 0, 0, 1, 2);
        step();
        set_wb(1, 2);                      // issue still held, dest R2
        at_neg();
        chk("sim_pre_inFlight", int'(bus.inFlight), 1);
        step();
        idle();
        at_neg();
        chk("sim_inFlight", int'(bus.inFlight), 1);
        step();
        set_wb(1, 2);
        step();
        idle();

        // Sticky error on R9, with one write outstanding to R1
        set_issue(1, 0, 0, 0, 1, 1);
        step();
        idle();
        set_wb(1, 9);
        step();
        idle();
        at_neg();
        chk("err_wbErr",    int'(bus.wbErr),    1);
        chk("err_inFlight", int'(bus.inFlight), 1);
        repeat (10) step();
        at_neg();
        chk("err_wbErr_hold", int'(bus.wbErr), 1);
        step();

        // Mid-operation asynchronous reset with inFlight = 4
        for (int r = 2; r <= 4; r++) begin
            set_issue(1, 0, 0, 0, 1, r);
            step();
        end
        set_issue(1, 1, 0, 0, 0, 0);       // reads R1, pending
        at_neg();
        chk("mid_inFlight", int'(bus.inFlight), 4);
        chk("mid_stall",    int'(bus.stall),    1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_inFlight", int'(bus.inFlight), 0);
        chk("arst_wbErr",    int'(bus.wbErr),    0);
        chk("arst_stall",    int'(bus.stall),    0);
        at_neg();
        step();
        rst = 1'b1;
        idle();
        repeat (2) step();
        at_neg();
        chk("post_inFlight", int'(bus.inFlight), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
